// File: rtl/two_mode_timer_pkg.sv
// Shared state encoding and count-direction constants for the two-mode timer.
package two_mode_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/two_mode_timer_ctrl_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled, freezes on hold, clears otherwise.
module tmr_prescaler #(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic hold,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      else if (!hold)
         cnt <= '0;
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/two_mode_timer_ctrl.sv
// Stopwatch / countdown timer controller with prescaled tick.
// Optional macro TMR_AUTO_RELOAD_EN: countdown reloads load_val on reaching 0 instead of expiring.
module two_mode_timer_ctrl
   import two_mode_timer_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_i,
   input  logic             start_stop,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] preset,
   output logic             running,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_d;
   logic             done_d;
   logic             mode_r;
   logic [WIDTH-1:0] load_r;
   logic             eff_mode;
   logic [WIDTH-1:0] eff_load;
   logic             tick;

   // IDLE tracks the live inputs; every other state uses the values captured on leaving IDLE.
   assign eff_mode = (state_q == ST_IDLE) ? mode_i   : mode_r;
   assign eff_load = (state_q == ST_IDLE) ? load_val : load_r;
   assign preset   = (eff_mode == MODE_DOWN) ? eff_load : '0;
   assign running  = (state_q == ST_RUN);

   tmr_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ST_RUN),
      .hold (state_q == ST_PAUSE),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      count_d = count;
      done_d  = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         count_d = preset;
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_d = preset;
               if (start_stop) begin
                  if (eff_mode == MODE_DOWN && load_val == '0) begin
                     state_d = ST_EXPIRED;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (tick) begin
                  if (mode_r == MODE_UP) begin
                     count_d = count + ONE;
                     done_d  = &count;
                  end else if (count == ONE) begin
                     done_d = 1'b1;
`ifdef TMR_AUTO_RELOAD_EN
                     count_d = load_r;
`else
                     count_d = '0;
                     state_d = ST_EXPIRED;
`endif
                  end else begin
                     count_d = count - ONE;
                  end
               end
               // A coinciding tick is applied first; expiry outranks the pause request.
               if (start_stop && state_d == ST_RUN)
                  state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (start_stop)
                  state_d = ST_RUN;
            end
            ST_EXPIRED: begin
               count_d = '0;
               if (start_stop)
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         count   <= '0;
         done    <= 1'b0;
         mode_r  <= MODE_UP;
         load_r  <= '0;
      end else begin
         state_q <= state_d;
         count   <= count_d;
         done    <= done_d;
         if (state_q == ST_IDLE) begin
            mode_r <= mode_i;
            load_r <= load_val;
         end
      end
   end

endmodule
